// File: rtl/freq_meter_if.sv
`default_nettype none
// ============================================================================
// Module      : freq_meter_if
// Description : Signal bundle between a frequency-meter client and the
//               gated edge counter (measurement input, controls, result).
// Revision    : 1.0 - initial release
// ============================================================================
interface freq_meter_if #(
    parameter int CNT_W = 32
) ();
    logic             i_sig;
    logic             i_en;
    logic             i_hold;
    logic [CNT_W-1:0] o_freq;
    logic             o_valid;
    logic             o_overflow;
    logic             o_busy;

    // Client side: drives the measured signal and controls, reads results
    modport master (
        output i_sig, i_en, i_hold,
        input  o_freq, o_valid, o_overflow, o_busy
    );

    // Meter side
    modport slave (
        input  i_sig, i_en, i_hold,
        output o_freq, o_valid, o_overflow, o_busy
    );
endinterface
`default_nettype wire

// File: rtl/freq_meter.sv
`default_nettype none
// ============================================================================
// Module      : freq_meter
// Description : Gated frequency counter. Counts synchronized rising edges of
//               an asynchronous input over back-to-back windows of
//               GATE_CYCLES clk cycles and publishes each window's count.
// Revision    : 1.0 - initial release
// ============================================================================
module freq_meter #(
    parameter int F_CLK       = 25000000,
    parameter int GATE_CYCLES = F_CLK,
    parameter int CNT_W       = 32
) (
    input  wire logic   clk,
    input  wire logic   rst,
    freq_meter_if.slave fm
);
    localparam int                  C_GATE_W    = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [C_GATE_W-1:0] C_GATE_LAST = C_GATE_W'(GATE_CYCLES - 1);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_MEASURE = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic                 w_close;
    logic                 w_run;

    logic                 r_s1;
    logic                 r_s2;
    logic                 r_s3;
    logic                 w_edge;

    logic [C_GATE_W-1:0]  r_gate_cnt;
    logic [CNT_W-1:0]     r_edge_cnt;
    logic                 r_sat;
    logic                 w_gate_last;
    logic                 w_edge_full;
    logic                 w_sat_hit;
    logic [CNT_W-1:0]     w_edge_cnt_inc;

    logic [CNT_W-1:0]     r_freq;
    logic                 r_valid;
    logic                 r_overflow;

    assign w_edge         = r_s2 & ~r_s3;
    assign w_gate_last    = (r_gate_cnt == C_GATE_LAST);
    assign w_edge_full    = &r_edge_cnt;
    assign w_sat_hit      = w_edge & w_edge_full;
    // Saturating count including an edge detected in the current cycle
    assign w_edge_cnt_inc = (w_edge && !w_edge_full) ? r_edge_cnt + CNT_W'(1) : r_edge_cnt;

    // Two-flop synchronizer plus delay flop for rising-edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= fm.i_sig;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: window close on the last gate cycle, abort on early disable
    always_comb begin
        w_state_next = r_state;
        w_close      = 1'b0;
        w_run        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (fm.i_en) begin
                    w_state_next = ST_MEASURE;
                end
            end
            ST_MEASURE: begin
                if (w_gate_last) begin
                    w_close = 1'b1;
                    if (!fm.i_en) begin
                        w_state_next = ST_IDLE;
                    end
                end else if (fm.i_en) begin
                    w_run = 1'b1;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Gate and edge counters; cleared whenever not mid-window so the next window starts at zero
    always_ff @(posedge clk) begin
        if (rst) begin
            r_gate_cnt <= '0;
            r_edge_cnt <= '0;
            r_sat      <= 1'b0;
        end else if (w_run) begin
            r_gate_cnt <= r_gate_cnt + C_GATE_W'(1);
            r_edge_cnt <= w_edge_cnt_inc;
            r_sat      <= r_sat | w_sat_hit;
        end else begin
            r_gate_cnt <= '0;
            r_edge_cnt <= '0;
            r_sat      <= 1'b0;
        end
    end

    // Publish the closing window's result unless the display hold is active
    always_ff @(posedge clk) begin
        if (rst) begin
            r_freq     <= '0;
            r_valid    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_valid <= w_close & ~fm.i_hold;
            if (w_close && !fm.i_hold) begin
                r_freq     <= w_edge_cnt_inc;
                r_overflow <= r_sat | w_sat_hit;
            end
        end
    end

    assign fm.o_freq     = r_freq;
    assign fm.o_valid    = r_valid;
    assign fm.o_overflow = r_overflow;
    assign fm.o_busy     = (r_state == ST_MEASURE);

endmodule
`default_nettype wire

// File: tb/tb_freq_meter.sv
`default_nettype none
// ============================================================================
// Module      : tb_freq_meter
// Description : Self-checking bench for freq_meter. Two instances with a
//               100-cycle gate: dut_a (CNT_W=4) and dut_b (CNT_W=8).
//               Expected publishes are queued per instance; monitors pop and
//               compare on every o_valid, including the cycle it arrives in.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_freq_meter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    // Test-signal generators: period 0 means i_sig is driven by hand
    int per_a = 0;
    int ph_a  = 0;
    int per_b = 0;
    int ph_b  = 0;
    int t0, t2, t3;

    typedef struct {
        int freq;
        int ovf;
        int cyc;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    freq_meter_if #(.CNT_W(4)) ifa ();
    freq_meter_if #(.CNT_W(8)) ifb ();

    freq_meter #(.F_CLK(100), .GATE_CYCLES(100), .CNT_W(4)) dut_a (
        .clk (clk),
        .rst (rst),
        .fm  (ifa)
    );

    freq_meter #(.F_CLK(100), .GATE_CYCLES(100), .CNT_W(8)) dut_b (
        .clk (clk),
        .rst (rst),
        .fm  (ifb)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t mk(input int f, input int o, input int c);
        exp_t e;
        e.freq = f;
        e.ovf  = o;
        e.cyc  = c;
        return e;
    endfunction

    // Monitor for dut_a
    always @(negedge clk) begin
        exp_t e;
        if (!rst && ifa.o_valid) begin
            if (qa.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL a_unexpected_valid: got o_freq=%0d at cycle %0d, expected no publish", ifa.o_freq, cyc);
            end else begin
                e = qa.pop_front();
                chk("a_freq", int'(ifa.o_freq), e.freq);
                chk("a_overflow", int'(ifa.o_overflow), e.ovf);
                chk("a_valid_cycle", cyc, e.cyc);
            end
        end
    end

    // Monitor for dut_b
    always @(negedge clk) begin
        exp_t e;
        if (!rst && ifb.o_valid) begin
            if (qb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL b_unexpected_valid: got o_freq=%0d at cycle %0d, expected no publish", ifb.o_freq, cyc);
            end else begin
                e = qb.pop_front();
                chk("b_freq", int'(ifb.o_freq), e.freq);
                chk("b_overflow", int'(ifb.o_overflow), e.ovf);
                chk("b_valid_cycle", cyc, e.cyc);
            end
        end
    end

    // One negedge step; generated signals start high at phase 0
    task automatic tick();
        @(negedge clk);
        if (per_a != 0) begin
            ifa.i_sig = (ph_a < per_a / 2);
            ph_a = (ph_a + 1 >= per_a) ? 0 : ph_a + 1;
        end
        if (per_b != 0) begin
            ifb.i_sig = (ph_b < per_b / 2);
            ph_b = (ph_b + 1 >= per_b) ? 0 : ph_b + 1;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk_reset_outputs();
        chk("a_rst_freq",  int'(ifa.o_freq), 0);
        chk("a_rst_valid", int'(ifa.o_valid), 0);
        chk("a_rst_ovf",   int'(ifa.o_overflow), 0);
        chk("a_rst_busy",  int'(ifa.o_busy), 0);
        chk("b_rst_freq",  int'(ifb.o_freq), 0);
        chk("b_rst_valid", int'(ifb.o_valid), 0);
        chk("b_rst_ovf",   int'(ifb.o_overflow), 0);
        chk("b_rst_busy",  int'(ifb.o_busy), 0);
    endtask

    initial begin
        ifa.i_sig = 1'b0; ifa.i_en = 1'b1; ifa.i_hold = 1'b0;
        ifb.i_sig = 1'b0; ifb.i_en = 1'b1; ifb.i_hold = 1'b0;

        // Reset held with enable high and the inputs toggling
        per_a = 6; ph_a = 0;
        per_b = 6; ph_b = 0;
        run(4);
        chk_reset_outputs();
        run(6);
        chk_reset_outputs();

        // Release reset with both instances enabled: a at period 4, b at period 10
        per_a = 4;  ph_a = 0;
        per_b = 10; ph_b = 0;
        tick();
        rst = 1'b0;
        t0 = cyc;
        qa.push_back(mk(15, 1, t0 + 101));
        qa.push_back(mk(10, 0, t0 + 201));
        qb.push_back(mk(10, 0, t0 + 101));
        qb.push_back(mk(10, 0, t0 + 201));

        // Second window of a: period 10 after saturating, overflow clears
        run(99);
        per_a = 10; ph_a = 0;
        tick();
        run(99);

        // a stops after its second window; b switches to period 20
        per_b = 20; ph_b = 0;
        tick();
        ifa.i_en = 1'b0;

        // Hold across b's third window close
        run(50);
        ifb.i_hold = 1'b1;
        run(90);
        chk("b_hold_freq", int'(ifb.o_freq), 10);
        run(10);
        ifb.i_hold = 1'b0;
        qb.push_back(mk(5, 0, t0 + 401));

        // Abort b at gate count 50 of the following window
        run(101);
        chk("b_busy_before_abort", int'(ifb.o_busy), 1);
        ifb.i_en = 1'b0;
        tick();
        chk("b_busy_after_abort", int'(ifb.o_busy), 0);
        chk("b_freq_after_abort", int'(ifb.o_freq), 5);
        chk("a_busy_idle", int'(ifa.o_busy), 0);

        // Re-enable: a full window must elapse before the next publish
        per_b = 0; ifb.i_sig = 1'b0;
        run(10);
        per_b = 10; ph_b = 0;
        tick();
        ifb.i_en = 1'b1;
        t2 = cyc;
        qb.push_back(mk(10, 0, t2 + 101));
        run(99);
        tick();
        ifb.i_en = 1'b0;
        run(5);

        // Single edge detected exactly on the close cycle
        per_b = 0; ifb.i_sig = 1'b0;
        run(5);
        tick();
        ifb.i_en = 1'b1;
        t3 = cyc;
        qb.push_back(mk(1, 0, t3 + 101));
        qb.push_back(mk(0, 0, t3 + 201));
        run(97);
        tick();
        ifb.i_sig = 1'b1;
        run(101);
        tick();
        ifb.i_en = 1'b0;
        run(5);

        chk("a_pending_results", qa.size(), 0);
        chk("b_pending_results", qb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
